// File: rtl/lmi_icache_fill_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : lmi_icache_fill_ctl
//  Description : Instruction-cache tag/data RAM sequencer. Refills a line from
//                the memory bus on a miss (critical-word-first or zero-first,
//                burst or per-word requests). Sweeps every tag entry invalid
//                on INVALIDATE. Grants external/debug access to the RAMs.
//  Revision    : 1.0  initial release
//
//  Ports
//    CLK, RESET_D1_R_N          clock (rising edge), async active-low reset
//    MISS_REQ, MISS_ADDR        level miss request and its fetch address
//    MEMSEQUENTIAL              1 = one burst per line, 0 = one request/word
//    MEMZEROFIRST               1 = fill from word 0, 0 = critical word first
//    INVALIDATE                 pulse, clears all tag valid bits
//    EXT_ICREQRAM_R/IC_GNTRAM_R external RAM access request / registered grant
//    MEM_REQ/MEM_ADDR/MEM_BURST memory read request
//    LACK, MEM_DATA             00 idle, 01 beat, 11 last beat, 10 error
//    FILL_DATA*                 data RAM index / write strobe / write data
//    FILL_TAG*                  tag RAM index / write strobe / {valid, tag}
//    FILL_BUSY/DONE/ERR         status and completion pulses
//
//  Optional feature macro: ICACHE_CRIT_FWD_EN
//    Adds CRIT_VALID / CRIT_DATA. These flag the beat that carries the
//    missing word so that the fetch pipeline can restart before the tag
//    write.
// ============================================================================
module lmi_icache_fill_ctl #(
    parameter int IC_ADDR_HI      = 12,
    parameter int LINE_WORDS_LOG2 = 2
) (
    input  logic                                  CLK,
    input  logic                                  RESET_D1_R_N,
    input  logic                                  MISS_REQ,
    input  logic [31:0]                           MISS_ADDR,
    input  logic                                  MEMSEQUENTIAL,
    input  logic                                  MEMZEROFIRST,
    input  logic                                  INVALIDATE,
    input  logic                                  EXT_ICREQRAM_R,
    output logic                                  IC_GNTRAM_R,
    output logic                                  MEM_REQ,
    output logic [31:0]                           MEM_ADDR,
    output logic                                  MEM_BURST,
    input  logic [1:0]                            LACK,
    input  logic [31:0]                           MEM_DATA,
    output logic [IC_ADDR_HI-2:0]                 FILL_DATAINDEX,
    output logic                                  FILL_DATAWE,
    output logic [31:0]                           FILL_DATAWR,
    output logic [IC_ADDR_HI-LINE_WORDS_LOG2-2:0] FILL_TAGINDEX,
    output logic                                  FILL_TAGWE,
    output logic [31-IC_ADDR_HI:0]                FILL_TAGWR,
    output logic                                  FILL_BUSY,
    output logic                                  FILL_DONE,
    output logic                                  FILL_ERR
`ifdef ICACHE_CRIT_FWD_EN
    ,
    output logic                                  CRIT_VALID,
    output logic [31:0]                           CRIT_DATA
`endif
);

    localparam int LW  = LINE_WORDS_LOG2;
    localparam int TIW = IC_ADDR_HI - LINE_WORDS_LOG2 - 1;  // tag index width

    localparam logic [LW-1:0]  ONE_WORD = 1;
    localparam logic [TIW-1:0] ONE_TAG  = 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INVAL  = 3'd1,
        S_EXTGNT = 3'd2,
        S_REQ    = 3'd3,
        S_FILL   = 3'd4,
        S_TAGWR  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            inval_q, inval_d;   // latched INVALIDATE awaiting IDLE
    logic            gnt_q, gnt_d;
    logic [TIW-1:0]  tidx_q, tidx_d;     // invalidate sweep index
    logic [LW-1:0]   start_q, start_d;   // first word of the fill order
    logic [LW-1:0]   cnt_q, cnt_d;       // beats accepted so far
    logic            seq_q, seq_d;       // burst mode captured at miss start

    logic [LW-1:0]   w_word;
    logic [TIW-1:0]  w_line;
    logic            w_unused_ok;

    // Fill order wraps inside the line because the sum is truncated to LW bits.
    assign w_word      = start_q + cnt_q;
    assign w_line      = MISS_ADDR[IC_ADDR_HI:LW+2];
    assign w_unused_ok = &{1'b0, MISS_ADDR[1:0]};

    always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
        if (!RESET_D1_R_N) begin
            state_q <= S_IDLE;
            inval_q <= 1'b0;
            gnt_q   <= 1'b0;
            tidx_q  <= '0;
            start_q <= '0;
            cnt_q   <= '0;
            seq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inval_q <= inval_d;
            gnt_q   <= gnt_d;
            tidx_q  <= tidx_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        inval_d        = inval_q | INVALIDATE;
        tidx_d         = tidx_q;
        start_d        = start_q;
        cnt_d          = cnt_q;
        seq_d          = seq_q;
        MEM_REQ        = 1'b0;
        MEM_ADDR       = '0;
        MEM_BURST      = 1'b0;
        FILL_DATAINDEX = '0;
        FILL_DATAWE    = 1'b0;
        FILL_DATAWR    = '0;
        FILL_TAGINDEX  = '0;
        FILL_TAGWE     = 1'b0;
        FILL_TAGWR     = '0;
        FILL_DONE      = 1'b0;
        FILL_ERR       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (inval_q || INVALIDATE) begin
                    state_d = S_INVAL;
                    inval_d = 1'b0;
                    tidx_d  = '0;
                end else if (EXT_ICREQRAM_R) begin
                    state_d = S_EXTGNT;
                end else if (MISS_REQ) begin
                    state_d = S_REQ;
                    start_d = MEMZEROFIRST ? '0 : MISS_ADDR[LW+1:2];
                    seq_d   = MEMSEQUENTIAL;
                    cnt_d   = '0;
                end
            end
            S_INVAL: begin
                FILL_TAGWE    = 1'b1;
                FILL_TAGINDEX = tidx_q;
                tidx_d        = tidx_q + ONE_TAG;
                if (&tidx_q) begin
                    state_d = S_IDLE;
                end
            end
            S_EXTGNT: begin
                if (!EXT_ICREQRAM_R) begin
                    state_d = S_IDLE;
                end
            end
            S_REQ, S_FILL: begin
                if (state_q == S_REQ) begin
                    MEM_REQ   = 1'b1;
                    MEM_ADDR  = {MISS_ADDR[31:LW+2], w_word, 2'b00};
                    MEM_BURST = seq_q;
                end
                if (LACK == 2'b10) begin
                    FILL_ERR = 1'b1;
                    state_d  = S_IDLE;
                end else if (LACK[0]) begin
                    // A beat may arrive while still in REQ; it is written immediately.
                    FILL_DATAWE    = 1'b1;
                    FILL_DATAWR    = MEM_DATA;
                    FILL_DATAINDEX = {w_line, w_word};
                    cnt_d          = cnt_q + ONE_WORD;
                    if (&cnt_q) begin
                        state_d = S_TAGWR;
                    end else if (!seq_q) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_TAGWR: begin
                FILL_TAGWE    = 1'b1;
                FILL_TAGINDEX = w_line;
                FILL_TAGWR    = {1'b1, MISS_ADDR[31:IC_ADDR_HI+1]};
                FILL_DONE     = 1'b1;
                cnt_d         = '0;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        gnt_d = (state_d == S_EXTGNT);
    end

    assign IC_GNTRAM_R = gnt_q;
    assign FILL_BUSY   = (state_q == S_INVAL) || (state_q == S_REQ) ||
                         (state_q == S_FILL)  || (state_q == S_TAGWR);

`ifdef ICACHE_CRIT_FWD_EN
    assign CRIT_VALID = FILL_DATAWE && (w_word == MISS_ADDR[LW+1:2]);
    assign CRIT_DATA  = CRIT_VALID ? MEM_DATA : 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lmi_icache_fill_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lmi_icache_fill_ctl
//  Description : Directed self-checking bench for lmi_icache_fill_ctl.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lmi_icache_fill_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_req, memseq, memzf, inval, ext_req;
    logic [31:0] miss_addr, mem_data;
    logic [1:0]  lack;
    logic        gnt, mem_req, mem_burst, datawe, tagwe, busy, done, err;
    logic [31:0] mem_addr, datawr;
    logic [10:0] dataidx;
    logic [8:0]  tagidx;
    logic [19:0] tagwr;
`ifdef ICACHE_CRIT_FWD_EN
    logic        crit_valid;
    logic [31:0] crit_data;
`endif

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] seen_idx  [4];
    logic [31:0] seen_addr [4];

    always #5 clk = ~clk;

    lmi_icache_fill_ctl #(.IC_ADDR_HI(12), .LINE_WORDS_LOG2(2)) dut (
        .CLK            (clk),
        .RESET_D1_R_N   (rst_n),
        .MISS_REQ       (miss_req),
        .MISS_ADDR      (miss_addr),
        .MEMSEQUENTIAL  (memseq),
        .MEMZEROFIRST   (memzf),
        .INVALIDATE     (inval),
        .EXT_ICREQRAM_R (ext_req),
        .IC_GNTRAM_R    (gnt),
        .MEM_REQ        (mem_req),
        .MEM_ADDR       (mem_addr),
        .MEM_BURST      (mem_burst),
        .LACK           (lack),
        .MEM_DATA       (mem_data),
        .FILL_DATAINDEX (dataidx),
        .FILL_DATAWE    (datawe),
        .FILL_DATAWR    (datawr),
        .FILL_TAGINDEX  (tagidx),
        .FILL_TAGWE     (tagwe),
        .FILL_TAGWR     (tagwr),
        .FILL_BUSY      (busy),
        .FILL_DONE      (done),
        .FILL_ERR       (err)
`ifdef ICACHE_CRIT_FWD_EN
        ,
        .CRIT_VALID     (crit_valid),
        .CRIT_DATA      (crit_data)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Every output must read zero (IDLE with no request, or reset).
    task automatic check_quiet(input string tag);
        check_eq(tag, 32'({mem_req, mem_burst, datawe, tagwe, done, err, busy, gnt}), 32'd0);
        check_eq(tag, mem_addr, 32'd0);
        check_eq(tag, 32'({dataidx, tagidx}), 32'd0);
        check_eq(tag, 32'(tagwr), 32'd0);
        check_eq(tag, datawr, 32'd0);
    endtask

    // Runs one miss with a directed memory responder. err_beat >= 0 answers
    // that beat with LACK=10. side pulses INVALIDATE and raises the external
    // request during the first REQ cycle.
    task automatic do_miss(input logic [31:0] addr, input logic zf, input logic seq,
                           input int err_beat, input logic side);
        logic [1:0]  s, w;
        logic [31:0] d;
        s = zf ? 2'd0 : addr[3:2];
        @(negedge clk);
        miss_req = 1'b1; miss_addr = addr; memzf = zf; memseq = seq; lack = 2'b00;
        #1 check_eq("miss_start_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            w = s + 2'(i);
            if (i == 0 || !seq) begin
                @(negedge clk);
                lack = 2'b00;
                if (side && i == 0) begin
                    inval = 1'b1; ext_req = 1'b1;
                end
                #1;
                seen_addr[i] = mem_addr;
                check_eq("req_mem_req", 32'(mem_req), 32'd1);
                check_eq("req_mem_addr", mem_addr, {addr[31:4], w, 2'b00});
                check_eq("req_burst", 32'(mem_burst), 32'(seq));
                check_eq("req_busy_we", 32'({busy, datawe, tagwe}), 32'b100);
            end
            @(negedge clk);
            inval    = 1'b0;
            d        = $urandom;
            mem_data = d;
            if (i == err_beat) begin
                lack = 2'b10;
                #1;
                check_eq("err_pulse", 32'(err), 32'd1);
                check_eq("err_no_write", 32'({datawe, tagwe, done}), 32'd0);
                miss_req = 1'b0;
                @(negedge clk);
                lack = 2'b00;
                #1 check_quiet("after_err_idle");
                return;
            end
            lack = (i == 3 || !seq) ? 2'b11 : 2'b01;
            #1;
            seen_idx[i] = 32'(dataidx);
            check_eq("beat_we", 32'({datawe, tagwe, err}), 32'b100);
            check_eq("beat_index", 32'(dataidx), 32'({addr[12:4], w}));
            check_eq("beat_wdata", datawr, d);
            check_eq("beat_mem_req", 32'(mem_req), 32'(i == 0 || !seq));
`ifdef ICACHE_CRIT_FWD_EN
            check_eq("crit_valid", 32'(crit_valid), 32'(w == addr[3:2]));
            check_eq("crit_data", crit_data, (w == addr[3:2]) ? d : 32'd0);
`endif
        end
        @(negedge clk);
        lack = 2'b00; miss_req = 1'b0;
        #1;
        check_eq("tagwr_strobe", 32'({tagwe, done, datawe, busy}), 32'b1101);
        check_eq("tagwr_index", 32'(tagidx), 32'(addr[12:4]));
        check_eq("tagwr_value", 32'(tagwr), 32'({1'b1, addr[31:13]}));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; miss_req = 1'b0; miss_addr = '0; memseq = 1'b0; memzf = 1'b0;
        inval = 1'b0; ext_req = 1'b0; lack = 2'b00; mem_data = '0;
        #12 check_quiet("reset_state");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1 check_quiet("idle_after_reset");

        // Burst, critical word first: words 2,3,0,1 of line 0x123.
        do_miss(32'h0000_1238, 1'b0, 1'b1, -1, 1'b0);
        check_eq("cwf_idx0", seen_idx[0], 32'h48E);
        check_eq("cwf_idx1", seen_idx[1], 32'h48F);
        check_eq("cwf_idx2", seen_idx[2], 32'h48C);
        check_eq("cwf_idx3", seen_idx[3], 32'h48D);

        // Per-word, zero first: four separate requests.
        do_miss(32'h0000_1238, 1'b1, 1'b0, -1, 1'b0);
        check_eq("pw_addr0", seen_addr[0], 32'h0000_1230);
        check_eq("pw_addr1", seen_addr[1], 32'h0000_1234);
        check_eq("pw_addr2", seen_addr[2], 32'h0000_1238);
        check_eq("pw_addr3", seen_addr[3], 32'h0000_123C);

        // Error on the second beat, then a clean retry.
        do_miss(32'h0000_1238, 1'b0, 1'b1, 1, 1'b0);
        do_miss(32'h0000_1238, 1'b0, 1'b1, -1, 1'b0);

        // Zero-first burst: the critical word is the third beat.
        do_miss(32'h0000_1238, 1'b1, 1'b1, -1, 1'b0);

        // External request beats a simultaneous miss.
        @(negedge clk);
        ext_req = 1'b1; miss_req = 1'b1; miss_addr = 32'h0000_0040; memseq = 1'b1; memzf = 1'b0;
        #1 check_eq("ext_gnt_wait", 32'(gnt), 32'd0);
        @(negedge clk); #1;
        check_eq("ext_granted", 32'({gnt, mem_req, busy, datawe, tagwe}), 32'b10000);
        ext_req = 1'b0;
        @(negedge clk); #1;
        check_eq("ext_dropped", 32'({gnt, mem_req}), 32'd0);
        miss_req = 1'b0;

        // Asynchronous reset in the middle of a burst.
        @(negedge clk);
        miss_req = 1'b1; miss_addr = 32'h0000_1238; memseq = 1'b1; memzf = 1'b0; lack = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); lack = 2'b01; mem_data = $urandom;
        end
        rst_n = 1'b0;
        #1 check_quiet("reset_mid_fill");
        miss_req = 1'b0; lack = 2'b00;
        @(negedge clk); rst_n = 1'b1;
        #1 check_quiet("idle_after_reset2");
        do_miss(32'h0000_3238, 1'b0, 1'b1, -1, 1'b0);

        // Invalidate and external request raised during a fill.
        do_miss(32'h0000_5A70, 1'b0, 1'b1, -1, 1'b1);
        @(negedge clk); #1;
        check_eq("inval_pending_idle", 32'({busy, gnt, tagwe}), 32'd0);
        for (int k = 0; k < 512; k++) begin
            @(negedge clk); #1;
            check_eq("sweep_ctl", 32'({tagwe, busy, gnt, tagwr}), 32'({3'b110, 20'd0}));
            check_eq("sweep_index", 32'(tagidx), 32'(k));
        end
        @(negedge clk); #1;
        check_eq("sweep_end_idle", 32'({busy, tagwe, gnt}), 32'd0);
        @(negedge clk); #1;
        check_eq("sweep_then_gnt", 32'({gnt, busy, tagwe}), 32'b100);
        ext_req = 1'b0;
        @(negedge clk); #1;
        check_eq("final_gnt_drop", 32'(gnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
